// File: rtl/alu_pkg.sv
// Shared ALU types and constants.
// Used by the result selector and its output buffer.
package alu_pkg;

   localparam int ALU_WIDTH   = 32;
   localparam int ALU_NUM_SRC = 4;

   typedef logic [ALU_WIDTH-1:0] alu_word_t;

   // Occupancy of a 2-entry buffer: 0, 1 or 2.
   localparam int BUF_DEPTH = 2;
   typedef logic [1:0] buf_cnt_t;

   localparam buf_cnt_t BUF_EMPTY = 2'd0;
   localparam buf_cnt_t BUF_FULL  = 2'd2;

endpackage

// File: rtl/mux_sel_buf_sel_buf2.sv
// sel_buf2: generic 2-entry valid/ready buffer.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready/in_data   : upstream handshake
//   out_valid/out_ready/out_data: downstream handshake
// in_ready depends only on registered occupancy, so there is no path
// from out_ready to in_ready. out_data is zero while the buffer is empty.
module sel_buf2
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   buf_cnt_t         count;
   logic             head;
   logic             tail;
   logic [WIDTH-1:0] mem [BUF_DEPTH];

   logic push;
   logic pop;

   assign in_ready  = (count != BUF_FULL);
   assign out_valid = (count != BUF_EMPTY);

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Pointer and occupancy state. On a simultaneous push and pop with
   // one entry held, head moves onto the entry just written.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= BUF_EMPTY;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; stale contents are hidden by the output mask.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= in_data;
   end

   assign out_data = out_valid ? mem[head] : '0;

endmodule

// File: rtl/mux_sel_buf.sv
// mux_sel_buf: NUM_IN-way gated word selector feeding a 2-entry buffer.
// Ports:
//   clk, reset (sync, active-high)
//   in_bus (NUM_IN packed words), sel, en, in_valid -> in_ready
//   out_data, out_valid <- out_ready
//   sel_err (sticky, out-of-range select accepted), err_clr
module mux_sel_buf
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int NUM_IN = ALU_NUM_SRC,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err,
   input  logic                    err_clr
);

   // An index with no matching word (only possible when NUM_IN is not
   // a power of two) yields zero, same as a disabled result.
   function automatic logic [WIDTH-1:0] pick(
      input logic [NUM_IN*WIDTH-1:0] bus,
      input logic [SEL_W-1:0]        idx,
      input logic                    gate
   );
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (int'(idx) == i) r = bus[i*WIDTH +: WIDTH];
      end
      return gate ? r : '0;
   endfunction

   logic [WIDTH-1:0] result;
   logic             sel_bad;
   logic             push;

   assign result  = pick(in_bus, sel, en);
   assign sel_bad = (int'(sel) >= NUM_IN);
   assign push    = in_valid && in_ready;

   sel_buf2 #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (result),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   // A new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err <= 1'b0;
      end else if (push && sel_bad) begin
         sel_err <= 1'b1;
      end else if (err_clr) begin
         sel_err <= 1'b0;
      end
   end

endmodule

// File: doc/mux_sel_buf.md
Name: mux_sel_buf

Overview:
- Parametrised, registered successor to the ALU's fixed 4-way 32-bit gated result selector.
- Selects one of NUM_IN operand words by binary index. An enable gates the result to zero, matching the existing enable-gating behaviour.
- Result is pushed into a 2-entry output buffer with valid/ready handshake, so ALU result paths can stall without losing data.
- Sits between the arithmetic units (adder/subtractor outputs) and the result writeback.

Parameters:
- WIDTH, 32, bit width of each input word and of the output.
- NUM_IN, 4, number of selectable inputs (>=2).
- SEL_W, $clog2(NUM_IN), select index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_bus  input  NUM_IN*WIDTH  packed inputs; word i = in_bus[i*WIDTH +: WIDTH]
- sel  input  SEL_W  binary index of the word to select
- en  input  1  result enable; 0 forces the selected result to all-zero
- in_valid  input  1  sel/en/in_bus valid this cycle
- in_ready  output  1  buffer can accept a transfer
- out_data  output  WIDTH  head-of-buffer result
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- sel_err  output  1  sticky: an accepted transfer had sel >= NUM_IN
- err_clr  input  1  clears sel_err

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-high, on port reset; it is sampled only on the rising edge of clk.
- Reset values: count=0, head=0, tail=0, out_valid=0, out_data=0, sel_err=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all buffered entries are discarded and no pop is reported. Storage contents need no reset, because out_data is masked while the buffer is empty.
- Selection (combinational, pre-buffer):
  - result = en ? word[sel] : 0.
  - If sel >= NUM_IN (non-power-of-2 NUM_IN), result = 0.
- Push: in_valid && in_ready at a clk edge writes result to entry[tail]; tail toggles.
- Pop: out_valid && out_ready at a clk edge; head toggles.
- Latency: a result pushed at edge k appears on out_data with out_valid=1 after edge k, provided the buffer was empty. Minimum latency is 1 cycle; there is no combinational in->out path.
- in_ready = (count != 2). It depends only on registered state and never on out_ready; there is no ready-through path.
- out_valid = (count != 0). out_data = entry[head] when out_valid=1, else 0.
- Data must stay stable while out_valid=1 and out_ready=0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle (count=1): count stays 1, and the pushed word becomes head after the pop.
- Full (count=2): in_ready=0. in_valid is ignored (no push); the upstream must hold.
- Empty (count=0) with out_ready=1: no pop, no underflow.
- sel_err:
  - Set on an accepted push with sel >= NUM_IN.
  - Cleared on err_clr.
  - If set and clear occur in the same cycle, set wins.
- en=0 pushes still occupy a buffer entry (value 0) and obey the handshake.
- Throughput: 1 transfer/cycle sustained when out_ready is held at 1.

Decomposition:
- Shared package alu_pkg:
  - constants ALU_WIDTH=32 and ALU_NUM_SRC=4
  - typedef alu_word_t (logic [ALU_WIDTH-1:0])
- One sub-module is natural: sel_buf2, a generic 2-entry valid/ready buffer parametrised on WIDTH, reusable by other ALU stages.
- The selector stays inline as a combinational function/loop in mux_sel_buf.

Test Plan:
- Reset, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel=2, en=1, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 one cycle later with out_data=0x33333333, then out_valid=0.
- Same inputs, sel=3, en=0 -> out_data=0x00000000 with out_valid=1; sel_err stays 0.
- out_ready=0, push sel=0 then sel=1 on consecutive cycles -> in_ready=0 after the second push; a third in_valid is not accepted. Raise out_ready -> outputs 0x11111111 then 0x22222222 in order, then empty.
- out_ready=1, in_valid=1 for 8 cycles with sel=0,1,2,3,0,1,2,3 -> 8 outputs on consecutive cycles in the same order; in_ready stays 1 throughout.
- NUM_IN=3 instance, push sel=3 -> out_data=0 and sel_err=1 stays set. err_clr together with a new bad push -> sel_err stays 1. err_clr alone -> sel_err=0.
- Two entries buffered, reset=1 for one edge -> out_valid=0, out_data=0, in_ready=1 after that edge; the stale entries never appear.
